trans_validator_pro: RTL and testbench



---
 rtl/trans_validator_pro_if.sv | 24 ++
 rtl/trans_validator_pro.sv | 188 ++++++++++++++++++
 tb/tb_trans_validator_pro.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/trans_validator_pro_if.sv
// rtl/trans_validator_pro_if.sv - packet in/out handshake bundle for the transaction validator
interface trans_validator_pro_if #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 15
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_status;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_status, out_valid, count
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_status, out_valid, count
    );
endinterface

// File: rtl/trans_validator_pro.sv
// rtl/trans_validator_pro.sv - account-table transfer validator with funds, overflow and capacity checks
module trans_validator_pro #(
    parameter int ID_W           = 48,
    parameter int AMT_W          = 22,
    parameter int BAL_W          = 24,
    parameter int DEPTH          = 16384,
    parameter int INIT_BAL       = 100,
    parameter int REPORT_REJECTS = 0,
    parameter int DATA_W         = 2*ID_W+AMT_W+10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    trans_validator_pro_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = ID_W + BAL_W;

    typedef enum logic [2:0] {
        S_IDLE, S_SEARCH, S_RESOLVE, S_CHECK, S_WR_SND, S_WR_RCV, S_OUT
    } state_t;

    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_status;
    logic [CW-1:0]     r_count, r_addr, r_rd_idx, r_need;
    logic              r_rd_vld, r_snd_found, r_rcv_found;
    logic [EW-1:0]     r_rd_data;
    logic [AW-1:0]     r_snd_ptr, r_rcv_ptr;
    logic [BAL_W-1:0]  r_snd_bal, r_rcv_bal;
    logic [EW-1:0]     r_mem [DEPTH];

    logic [ID_W-1:0]   w_snd_id, w_rcv_id, w_ent_id;
    logic [BAL_W-1:0]  w_amt, w_ent_bal;
    logic [BAL_W:0]    w_rcv_sum;
    logic [CW-1:0]     w_need, w_cnt_sum;
    logic [AW-1:0]     w_new_snd_ptr, w_new_rcv_ptr, w_waddr;
    logic [EW-1:0]     w_wdata;
    logic              w_self, w_cmp, w_snd_hit, w_rcv_hit, w_search_done;
    logic              w_full, w_insuf, w_ovf, w_emit, w_we;
    logic              w_in_ready, w_out_valid;

    assign w_snd_id  = r_data[DATA_W-1 -: ID_W];
    assign w_rcv_id  = r_data[DATA_W-1-ID_W -: ID_W];
    assign w_amt     = BAL_W'(r_data[AMT_W+9:10]);
    assign w_self    = (w_snd_id == w_rcv_id);

    // Table entries only count as live below r_count; anything above is stale RAM.
    assign w_ent_id  = r_rd_data[EW-1 -: ID_W];
    assign w_ent_bal = r_rd_data[BAL_W-1:0];
    assign w_cmp     = r_rd_vld && (r_rd_idx < r_count);
    assign w_snd_hit = w_cmp && !r_snd_found && (w_ent_id == w_snd_id);
    assign w_rcv_hit = w_cmp && !r_rcv_found && (w_ent_id == w_rcv_id);
    assign w_search_done = ((r_snd_found || w_snd_hit) && (r_rcv_found || w_rcv_hit))
                           || (r_addr == r_count);

    // A self-transfer is one account, so it never needs a second slot.
    assign w_need        = CW'(!r_snd_found) + CW'(!r_rcv_found && !w_self);
    assign w_cnt_sum     = r_count + w_need;
    assign w_full        = (w_cnt_sum > CW'(DEPTH));
    assign w_new_snd_ptr = r_count[AW-1:0];
    assign w_new_rcv_ptr = r_count[AW-1:0] + AW'(!r_snd_found);

    assign w_rcv_sum = {1'b0, r_rcv_bal} + {1'b0, w_amt};
    assign w_insuf   = (r_snd_bal < w_amt);
    assign w_ovf     = w_rcv_sum[BAL_W] && !w_self;
    assign w_emit    = (r_status == 2'd0) || (REPORT_REJECTS != 0);

    assign w_we    = (r_state == S_WR_SND) || (r_state == S_WR_RCV);
    assign w_waddr = (r_state == S_WR_SND) ? r_snd_ptr : r_rcv_ptr;
    assign w_wdata = (r_state == S_WR_SND) ? {w_snd_id, r_snd_bal} : {w_rcv_id, r_rcv_bal};

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = r_data;
    assign bus.out_status = r_status;
    assign bus.count      = r_count;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = S_SEARCH;
            end
            S_SEARCH:  if (w_search_done) w_next = S_RESOLVE;
            S_RESOLVE: w_next = w_full ? S_OUT : S_CHECK;
            S_CHECK:   w_next = (w_insuf || w_ovf) ? S_OUT : S_WR_SND;
            S_WR_SND:  w_next = w_self ? S_OUT : S_WR_RCV;
            S_WR_RCV:  w_next = S_OUT;
            S_OUT: begin
                if (w_emit) begin
                    w_out_valid = 1'b1;
                    if (bus.out_ready) w_next = S_IDLE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Packet latch, search, allocation, balance check and count commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_status    <= 2'd0;
            r_count     <= '0;
            r_addr      <= '0;
            r_rd_idx    <= '0;
            r_need      <= '0;
            r_rd_vld    <= 1'b0;
            r_snd_found <= 1'b0;
            r_rcv_found <= 1'b0;
            r_snd_ptr   <= '0;
            r_rcv_ptr   <= '0;
            r_snd_bal   <= '0;
            r_rcv_bal   <= '0;
        end else begin
            r_rd_vld <= (r_state == S_SEARCH);
            r_rd_idx <= r_addr;
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_data      <= bus.in_data;
                    r_status    <= 2'd0;
                    r_addr      <= '0;
                    r_snd_found <= 1'b0;
                    r_rcv_found <= 1'b0;
                    if (bus.in_data[9]) r_count <= '0;
                end
                S_SEARCH: begin
                    r_addr <= r_addr + CW'(1);
                    if (w_snd_hit) begin
                        r_snd_found <= 1'b1;
                        r_snd_ptr   <= r_rd_idx[AW-1:0];
                        r_snd_bal   <= w_ent_bal;
                    end
                    if (w_rcv_hit) begin
                        r_rcv_found <= 1'b1;
                        r_rcv_ptr   <= r_rd_idx[AW-1:0];
                        r_rcv_bal   <= w_ent_bal;
                    end
                end
                S_RESOLVE: begin
                    if (w_full) begin
                        r_status <= 2'd2;
                    end else begin
                        r_need <= w_need;
                        if (!r_snd_found) begin
                            r_snd_ptr <= w_new_snd_ptr;
                            r_snd_bal <= BAL_W'(INIT_BAL);
                        end
                        if (!r_rcv_found) begin
                            r_rcv_ptr <= w_self ? w_new_snd_ptr : w_new_rcv_ptr;
                            r_rcv_bal <= BAL_W'(INIT_BAL);
                        end
                    end
                end
                S_CHECK: begin
                    if (w_insuf)      r_status <= 2'd1;
                    else if (w_ovf)   r_status <= 2'd3;
                    else if (!w_self) begin
                        r_snd_bal <= r_snd_bal - w_amt;
                        r_rcv_bal <= w_rcv_sum[BAL_W-1:0];
                    end
                end
                S_WR_SND: if (w_self) r_count <= r_count + r_need;
                S_WR_RCV: r_count <= r_count + r_need;
                default: ;
            endcase
        end
    end

    // Account table: single write port, registered read.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
        r_rd_data <= r_mem[r_addr[AW-1:0]];
    end
endmodule

// File: tb/tb_trans_validator_pro.sv
// tb/tb_trans_validator_pro.sv - scoreboard bench over three validator configurations
module tb_trans_validator_pro;
    localparam int DW = 50;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0][DW-1:0] s_in_data, s_out_data;
    logic [2:0]         s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [2:0][1:0]    s_out_status;
    logic [2:0][CW-1:0] s_count;

    // dut 0: 24-bit balances, init 100, reports rejects
    // dut 1: 8-bit balances, init 200, reports rejects
    // dut 2: 24-bit balances, init 100, drops rejects
    for (genvar g = 0; g < 3; g++) begin : g_dut
        trans_validator_pro_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
        assign bus.in_data     = s_in_data[g];
        assign bus.in_valid    = s_in_valid[g];
        assign bus.out_ready   = s_out_ready[g];
        assign s_in_ready[g]   = bus.in_ready;
        assign s_out_data[g]   = bus.out_data;
        assign s_out_status[g] = bus.out_status;
        assign s_out_valid[g]  = bus.out_valid;
        assign s_count[g]      = bus.count;
        trans_validator_pro #(
            .ID_W(16), .AMT_W(8), .BAL_W((g == 1) ? 8 : 24), .DEPTH(4),
            .INIT_BAL((g == 1) ? 200 : 100), .REPORT_REJECTS((g == 2) ? 0 : 1), .DATA_W(DW)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    typedef struct {
        int           d;
        logic [DW-1:0] data;
        logic [1:0]    st;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   seq     = 0;

    localparam logic [15:0] A = 16'hA001, B = 16'hB002, C = 16'hC003;
    localparam logic [15:0] D = 16'hD004, E = 16'hE005, F = 16'hF006;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int g = 0; g < 3; g++) begin
                if (s_out_valid[g] && s_out_ready[g]) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_out: dut%0d status %0d, nothing expected", g, s_out_status[g]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_dut", 64'(g), 64'(e.d));
                        chk("out_data", 64'(s_out_data[g]), 64'(e.data));
                        chk("out_status", 64'(s_out_status[g]), 64'(e.st));
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] mk(input logic [15:0] s, input logic [15:0] r,
                                         input logic [7:0] a, input logic bs, input int n);
        logic [8:0] fill;
        fill = 9'(n * 37 + 5);
        return {s, r, a, bs, fill};
    endfunction

    task automatic issue(input int d, input logic [DW-1:0] pkt);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        s_in_data[d]  = pkt;
        s_in_valid[d] = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (s_in_ready[d]) ok = 1;
        end
        if (!ok) chk("accept_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        s_in_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, input logic [CW-1:0] exp_cnt);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (s_in_ready[d]) ok = 1;
        end
        chk("idle_reached", 64'(ok), 64'(1));
        chk("count", 64'(s_count[d]), 64'(exp_cnt));
    endtask

    task automatic send(input int d, input logic [15:0] s, input logic [15:0] r, input logic [7:0] a,
                        input logic bs, input logic [1:0] st, input bit emit, input logic [CW-1:0] exp_cnt);
        logic [DW-1:0] pkt;
        pkt = mk(s, r, a, bs, seq);
        seq++;
        if (emit) exp_q.push_back('{d, pkt, st});
        issue(d, pkt);
        wait_idle(d, exp_cnt);
    endtask

    initial begin
        logic [DW-1:0] pkt;
        bit ok;
        s_in_data   = '0;
        s_in_valid  = '0;
        s_out_ready = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("rst_in_ready", 64'(s_in_ready[g]), 64'(1));
            chk("rst_out_valid", 64'(s_out_valid[g]), 64'(0));
            chk("rst_out_data", 64'(s_out_data[g]), 64'(0));
            chk("rst_out_status", 64'(s_out_status[g]), 64'(0));
            chk("rst_count", 64'(s_count[g]), 64'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // dut 0: funds, self-transfer, table capacity
        send(0, A, B, 8'd30,  1'b1, 2'd0, 1, 3'd2);
        send(0, A, B, 8'd0,   1'b0, 2'd0, 1, 3'd2);
        send(0, A, B, 8'd71,  1'b0, 2'd1, 1, 3'd2);
        send(0, A, B, 8'd80,  1'b0, 2'd1, 1, 3'd2);
        send(0, B, A, 8'd131, 1'b0, 2'd1, 1, 3'd2);
        send(0, B, A, 8'd130, 1'b0, 2'd0, 1, 3'd2);
        send(0, A, A, 8'd201, 1'b0, 2'd1, 1, 3'd2);
        send(0, A, A, 8'd200, 1'b0, 2'd0, 1, 3'd2);
        send(0, A, B, 8'd200, 1'b0, 2'd0, 1, 3'd2);
        send(0, C, D, 8'd5,   1'b0, 2'd0, 1, 3'd4);
        send(0, E, F, 8'd1,   1'b0, 2'd2, 1, 3'd4);
        send(0, E, A, 8'd1,   1'b0, 2'd2, 1, 3'd4);
        send(0, C, A, 8'd95,  1'b0, 2'd0, 1, 3'd4);
        send(0, C, A, 8'd1,   1'b0, 2'd1, 1, 3'd4);

        // dut 1: receiver overflow at 8-bit balances
        send(1, A, B, 8'd100, 1'b1, 2'd3, 1, 3'd0);
        send(1, A, B, 8'd201, 1'b0, 2'd1, 1, 3'd0);
        send(1, A, B, 8'd55,  1'b0, 2'd0, 1, 3'd2);
        send(1, C, B, 8'd1,   1'b0, 2'd3, 1, 3'd2);
        send(1, A, B, 8'd0,   1'b0, 2'd0, 1, 3'd2);

        // dut 2: rejects are dropped without output
        send(2, A, B, 8'd30,  1'b1, 2'd0, 1, 3'd2);
        send(2, A, B, 8'd80,  1'b0, 2'd1, 0, 3'd2);
        send(2, A, B, 8'd70,  1'b0, 2'd0, 1, 3'd2);
        send(2, B, C, 8'd201, 1'b0, 2'd1, 0, 3'd2);
        send(2, B, C, 8'd200, 1'b0, 2'd0, 1, 3'd3);

        // dut 0: output held under backpressure
        s_out_ready[0] = 1'b0;
        pkt = mk(D, C, 8'd5, 1'b0, seq);
        seq++;
        exp_q.push_back('{0, pkt, 2'd0});
        issue(0, pkt);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (s_out_valid[0]) ok = 1;
        end
        chk("stall_valid_seen", 64'(ok), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(s_out_valid[0]), 64'(1));
            chk("stall_data", 64'(s_out_data[0]), 64'(pkt));
            chk("stall_status", 64'(s_out_status[0]), 64'(0));
            chk("stall_in_ready", 64'(s_in_ready[0]), 64'(0));
        end
        s_out_ready[0] = 1'b1;
        wait_idle(0, 3'd4);

        // dut 0: reset during SEARCH, then a fresh table
        pkt = mk(A, B, 8'd1, 1'b0, seq);
        seq++;
        issue(0, pkt);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_ready", 64'(s_in_ready[0]), 64'(1));
        chk("midrst_out_valid", 64'(s_out_valid[0]), 64'(0));
        chk("midrst_out_data", 64'(s_out_data[0]), 64'(0));
        chk("midrst_out_status", 64'(s_out_status[0]), 64'(0));
        chk("midrst_count", 64'(s_count[0]), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        send(0, A, B, 8'd30, 1'b0, 2'd0, 1, 3'd2);
        send(0, A, B, 8'd71, 1'b0, 2'd1, 1, 3'd2);
        send(0, A, B, 8'd70, 1'b0, 2'd0, 1, 3'd2);

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
